// File: rtl/coherence_bus_arbiter_pkg.sv
// coherence_bus_arbiter_pkg: shared types and constants for the snooping-bus controller
//   bus_state_t : controller FSM states
//   bus_op_t    : latched transaction kind
//   FS_*        : fill_src encodings reported with grant
package coherence_bus_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, SNOOP, RESOLVE, MEM_WAIT, DONE} bus_state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_INV} bus_op_t;
  localparam logic [1:0] FS_NONE = 2'b00;
  localparam logic [1:0] FS_MEM  = 2'b01;
  localparam logic [1:0] FS_PEER = 2'b10;
endpackage

// File: rtl/coherence_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester strictly after ptr
//   req        in  NUM_CPUS  request vector
//   ptr        in  PTR_W     index of the last served core
//   winner     out NUM_CPUS  one-hot winner
//   winner_idx out PTR_W     winner index
//   valid      out 1         any request present
module rr_arbiter #(
  parameter int NUM_CPUS = 4,
  parameter int PTR_W = 2
) (
  input  logic [NUM_CPUS-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_CPUS-1:0] winner,
  output logic [PTR_W-1:0]    winner_idx,
  output logic                valid
);
  logic [PTR_W-1:0] j;
  always_comb begin
    winner = '0;
    winner_idx = '0;
    valid = 1'b0;
    j = '0;
    for (int k = 1; k <= NUM_CPUS; k++) begin
      j = PTR_W'((int'(ptr) + k) % NUM_CPUS);
      if (!valid && req[j]) begin
        valid = 1'b1;
        winner_idx = j;
        winner[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter: round-robin snooping-bus controller for NUM_CPUS caches
//   req_rd_miss/req_wr_miss/req_inv in  per-core level requests, req_addr per-core line address
//   grant        out one-hot completion pulse, with fill_data/fill_src
//   snoop_search/snoop_inv/snoop_addr out broadcast to non-owner cores
//   snoop_found/snoop_data in  peer hit responses, one cycle after search
//   mem_re/mem_addr out, mem_rdy/mem_rdata in  unified-memory read handshake
//   busy         out high whenever not IDLE
module coherence_bus_arbiter #(
  parameter int NUM_CPUS = 4,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CPUS-1:0]        req_rd_miss,
  input  logic [NUM_CPUS-1:0]        req_wr_miss,
  input  logic [NUM_CPUS-1:0]        req_inv,
  input  logic [NUM_CPUS*ADDR_W-1:0] req_addr,
  output logic [NUM_CPUS-1:0]        grant,
  output logic [NUM_CPUS-1:0]        snoop_search,
  output logic [ADDR_W-1:0]          snoop_addr,
  input  logic [NUM_CPUS-1:0]        snoop_found,
  input  logic [NUM_CPUS*DATA_W-1:0] snoop_data,
  output logic [NUM_CPUS-1:0]        snoop_inv,
  output logic [DATA_W-1:0]          fill_data,
  output logic [1:0]                 fill_src,
  output logic                       mem_re,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_rdy,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy
);
  import coherence_bus_arbiter_pkg::*;
  localparam int PTR_W = NUM_CPUS > 1 ? $clog2(NUM_CPUS) : 1;
  bus_state_t state, state_nx;
  bus_op_t op_q, win_op;
  logic [PTR_W-1:0] rr_ptr, owner, win_idx;
  logic [NUM_CPUS-1:0] mask, req_any, win_oh, owner_oh, others, hits;
  logic win_valid, peer_hit;
  logic [ADDR_W-1:0] addr_q, win_addr;
  logic [DATA_W-1:0] peer_data;
  // The just-served core is masked for one IDLE cycle while its request drains.
  assign req_any = (req_rd_miss | req_wr_miss | req_inv) & ~mask;
  rr_arbiter #(.NUM_CPUS(NUM_CPUS), .PTR_W(PTR_W)) u_arb (
    .req(req_any),
    .ptr(rr_ptr),
    .winner(win_oh),
    .winner_idx(win_idx),
    .valid(win_valid)
  );
  assign win_op = |(req_inv & win_oh) ? OP_INV : |(req_wr_miss & win_oh) ? OP_WR : OP_RD;
  assign win_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign owner_oh = NUM_CPUS'(1) << owner;
  assign others = ~owner_oh;
  assign hits = snoop_found & others;
  assign peer_hit = |hits;
  assign busy = state != IDLE;
  // Descending scan so the lowest-index hitting core supplies the data.
  always_comb begin
    peer_data = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--)
      if (hits[i]) peer_data = snoop_data[i*DATA_W +: DATA_W];
  end
  always_comb begin
    state_nx = state;
    grant = '0;
    snoop_search = '0;
    snoop_inv = '0;
    snoop_addr = '0;
    mem_re = 1'b0;
    mem_addr = '0;
    case (state)
      IDLE: state_nx = win_valid ? SNOOP : IDLE;
      SNOOP: begin
        state_nx = op_q == OP_INV ? DONE : RESOLVE;
        snoop_addr = addr_q;
        snoop_inv = op_q == OP_INV ? others : '0;
        snoop_search = op_q == OP_INV ? '0 : others;
      end
      RESOLVE: begin
        state_nx = peer_hit ? DONE : MEM_WAIT;
        // A write miss served by a peer invalidates every other copy right away.
        snoop_inv = op_q == OP_WR && peer_hit ? others : '0;
        snoop_addr = op_q == OP_WR && peer_hit ? addr_q : '0;
      end
      MEM_WAIT: begin
        state_nx = mem_rdy ? DONE : MEM_WAIT;
        mem_re = 1'b1;
        mem_addr = addr_q;
      end
      DONE: begin
        state_nx = IDLE;
        grant = owner_oh;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= PTR_W'(NUM_CPUS - 1);
      mask <= '0;
      owner <= '0;
      op_q <= OP_RD;
      addr_q <= '0;
      fill_data <= '0;
      fill_src <= FS_NONE;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          mask <= '0;
          if (win_valid) begin
            owner <= win_idx;
            op_q <= win_op;
            addr_q <= win_addr;
          end
        end
        SNOOP: if (op_q == OP_INV) fill_src <= FS_NONE;
        RESOLVE: if (peer_hit) begin
          fill_data <= peer_data;
          fill_src <= FS_PEER;
        end
        MEM_WAIT: if (mem_rdy) begin
          fill_data <= mem_rdata;
          fill_src <= FS_MEM;
        end
        DONE: begin
          rr_ptr <= owner;
          mask <= owner_oh;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// tb_coherence_bus_arbiter: table vectors, hand sequences and a randomized run against a transaction model
module tb_coherence_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_rd_miss = '0, req_wr_miss = '0, req_inv = '0;
  logic [51:0] req_addr = '0;
  logic [3:0] grant, snoop_search, snoop_inv;
  logic [12:0] snoop_addr, mem_addr;
  logic [3:0] snoop_found = '0;
  logic [63:0] snoop_data = '0;
  logic [15:0] fill_data;
  logic [1:0] fill_src;
  logic mem_re, busy;
  logic mem_rdy = 1'b0;
  logic [15:0] mem_rdata = '0;

  coherence_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd_miss(req_rd_miss), .req_wr_miss(req_wr_miss), .req_inv(req_inv), .req_addr(req_addr),
    .grant(grant), .snoop_search(snoop_search), .snoop_addr(snoop_addr),
    .snoop_found(snoop_found), .snoop_data(snoop_data), .snoop_inv(snoop_inv),
    .fill_data(fill_data), .fill_src(fill_src),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int core;
    int op;
    logic [12:0] addr;
    logic [3:0] found;
    logic [63:0] fdata;
    int mdelay;
    logic [15:0] mdata;
    bit drop;
    logic [1:0] src;
    logic [15:0] data;
    int lat;
  } vec_t;

  vec_t tbl[8];
  int checks = 0, errors = 0, cyc = 0;
  int order[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int core, input int op, input logic [12:0] addr, input bit on);
    req_rd_miss[core] = on && op == 0;
    req_wr_miss[core] = on && op == 1;
    req_inv[core] = on && op == 2;
    req_addr[core*13 +: 13] = addr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_rd_miss = '0;
    req_wr_miss = '0;
    req_inv = '0;
    snoop_found = '0;
    mem_rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic run_txn(input vec_t v);
    int t0;
    logic [3:0] oth, hit;
    oth = 4'hF & ~(4'b1 << v.core);
    set_req(v.core, v.op, v.addr, 1'b1);
    t0 = cyc;
    tick();
    chk("snoop_busy", busy, 1);
    chk("snoop_addr", snoop_addr, v.addr);
    chk("snoop_search", snoop_search, v.op == 2 ? 4'b0 : oth);
    chk("snoop_inv", snoop_inv, v.op == 2 ? oth : 4'b0);
    chk("snoop_mem_re", mem_re, 0);
    if (v.drop) set_req(v.core, v.op, v.addr, 1'b0);
    if (v.op != 2) begin
      tick();
      snoop_found = v.found;
      snoop_data = v.fdata;
      #1;
      hit = v.found & oth;
      chk("resolve_inv", snoop_inv, (hit != 0 && v.op == 1) ? oth : 4'b0);
      chk("resolve_mem_re", mem_re, 0);
      tick();
      snoop_found = '0;
      if (hit == 0) begin
        for (int i = 0; i < v.mdelay; i++) begin
          chk("wait_mem_re", mem_re, 1);
          chk("wait_mem_addr", mem_addr, v.addr);
          tick();
        end
        mem_rdy = 1'b1;
        mem_rdata = v.mdata;
        chk("rdy_mem_re", mem_re, 1);
        tick();
        mem_rdy = 1'b0;
      end
    end else tick();
    chk("done_grant", grant, 4'b1 << v.core);
    chk("done_fill_src", fill_src, v.src);
    if (v.src != 0) chk("done_fill_data", fill_data, v.data);
    chk("done_latency", cyc - t0, v.lat);
    chk("done_mem_re", mem_re, 0);
    chk("done_snoop_addr", snoop_addr, 0);
    set_req(v.core, v.op, v.addr, 1'b0);
    tick();
    chk("after_grant", grant, 0);
    chk("after_busy", busy, 0);
    chk("hold_fill_src", fill_src, v.src);
    if (v.src != 0) chk("hold_fill_data", fill_data, v.data);
  endtask

  // Inv requests from several cores; each stays high one cycle after its grant,
  // then drops. Optionally one core re-raises three cycles after its grant.
  task automatic run_multi(input logic [3:0] init, input int reraise, input int ncyc);
    logic [3:0] pend;
    int drop_at[4];
    int raise_at;
    int idx;
    pend = init;
    raise_at = -1;
    for (int i = 0; i < 4; i++) drop_at[i] = -1;
    order.delete();
    req_inv = pend;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      for (int i = 0; i < 4; i++) if (drop_at[i] == c) pend[i] = 1'b0;
      if (raise_at == c) pend[reraise] = 1'b1;
      req_inv = pend;
      if (grant != 0) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) idx = i;
        order.push_back(idx);
        drop_at[idx] = c + 2;
        if (idx == reraise && raise_at < 0) raise_at = c + 3;
      end
    end
    req_inv = '0;
    tick();
    tick();
  endtask

  logic [3:0] rpend, prev_req, cur_req, g1, g2, gnow, oth_r, hit_r;
  int rop[4], rdrop[4];
  logic [12:0] raddr[4];
  bit in_txn, srch_prev, mem_act;
  int t_owner, t_start, t_done, mem_cnt, last_g, w;
  logic [1:0] t_src;
  logic [15:0] t_data;

  initial begin
    tbl[0] = '{2, 0, 13'h0A5, 4'b0000, 64'h0, 4, 16'hBEEF, 1'b0, 2'b01, 16'hBEEF, 8};
    tbl[1] = '{0, 1, 13'h1F0, 4'b1000, 64'h1234_0000_0000_0000, 0, 16'h0, 1'b0, 2'b10, 16'h1234, 3};
    tbl[2] = '{1, 2, 13'h003, 4'b0000, 64'h0, 0, 16'h0, 1'b0, 2'b00, 16'h0, 2};
    tbl[3] = '{0, 0, 13'h0C3, 4'b0111, 64'h0000_2222_1111_DEAD, 0, 16'h0, 1'b0, 2'b10, 16'h1111, 3};
    tbl[4] = '{3, 1, 13'h155, 4'b0000, 64'h0, 0, 16'hA5A5, 1'b0, 2'b01, 16'hA5A5, 4};
    tbl[5] = '{1, 0, 13'h1ABC, 4'b0010, 64'h0000_0000_9999_0000, 1, 16'h7777, 1'b0, 2'b01, 16'h7777, 5};
    tbl[6] = '{2, 2, 13'h1FFF, 4'b0000, 64'h0, 0, 16'h0, 1'b0, 2'b00, 16'h0, 2};
    tbl[7] = '{3, 1, 13'h0777, 4'b0001, 64'h0000_0000_0000_0BAD, 0, 16'h0, 1'b1, 2'b10, 16'h0BAD, 3};

    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_search", snoop_search, 0);
    chk("rst_sinv", snoop_inv, 0);
    chk("rst_saddr", snoop_addr, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_src", fill_src, 0);
    chk("rst_fill_data", fill_data, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Round robin with mask: 0,1,3 together, 0 re-raised after its grant.
    do_reset();
    run_multi(4'b1011, 0, 30);
    chk("rr_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("rr_first", order[0], 0);
      chk("rr_second", order[1], 1);
      chk("rr_third", order[2], 3);
      chk("rr_fourth", order[3], 0);
    end

    // Reset in MEM_WAIT abandons the transaction; core 0 then wins first again.
    set_req(2, 0, 13'h0AA, 1'b1);
    begin
      int n;
      n = 0;
      while (!mem_re && n < 10) begin
        tick();
        n++;
      end
      chk("mrst_reached_mem", mem_re, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_mem_re", mem_re, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_grant", grant, 0);
    chk("mrst_mem_addr", mem_addr, 0);
    set_req(2, 0, 13'h0AA, 1'b0);
    tick();
    rst_n = 1'b1;
    run_multi(4'b0101, -1, 14);
    chk("mrst_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("mrst_first", order[0], 0);
      chk("mrst_second", order[1], 2);
    end

    // Randomized traffic against a transaction-level model.
    do_reset();
    rpend = '0; prev_req = '0; g1 = '0; g2 = '0;
    in_txn = 0; srch_prev = 0; mem_act = 0; last_g = 3;
    t_owner = 0; t_start = 0; t_done = -1; t_src = 0; t_data = 0; oth_r = 0; mem_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      rop[i] = 0;
      rdrop[i] = -1;
      raddr[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (rpend[i] && rdrop[i] == c) rpend[i] = 1'b0;
        else if (!rpend[i] && $urandom_range(3) == 0) begin
          rpend[i] = 1'b1;
          rop[i] = $urandom_range(2);
          raddr[i] = 13'($urandom);
          rdrop[i] = -1;
        end
        req_rd_miss[i] = rpend[i] && rop[i] == 0;
        req_wr_miss[i] = rpend[i] && rop[i] == 1;
        req_inv[i] = rpend[i] && rop[i] == 2;
        req_addr[i*13 +: 13] = raddr[i];
      end
      cur_req = rpend;
      snoop_found = (srch_prev && $urandom_range(1) == 1) ? 4'($urandom) : 4'b0;
      snoop_data = {$urandom, $urandom};
      mem_rdy = 1'b0;
      if (mem_re) begin
        if (!mem_act) begin
          mem_act = 1;
          mem_cnt = $urandom_range(3);
        end
        if (mem_cnt == 0) begin
          mem_rdy = 1'b1;
          mem_rdata = 16'($urandom);
          mem_act = 0;
        end else mem_cnt--;
      end
      #1;
      srch_prev = |snoop_search;
      gnow = '0;
      if (!in_txn && busy) begin
        w = rr_pick(prev_req & ~g2, last_g);
        if (w < 0) begin
          checks++;
          errors++;
          $display("FAIL rand_start: busy=1 expected 0 with no eligible request");
        end else begin
          in_txn = 1;
          t_owner = w;
          t_start = c;
          t_src = 2'b00;
          t_done = rop[w] == 2 ? c + 1 : -1;
          oth_r = 4'hF & ~(4'b1 << w);
          chk("rand_snoop_addr", snoop_addr, raddr[w]);
          chk("rand_search", snoop_search, rop[w] == 2 ? 4'b0 : oth_r);
          chk("rand_sinv", snoop_inv, rop[w] == 2 ? oth_r : 4'b0);
        end
      end else if (in_txn && rop[t_owner] != 2 && c == t_start + 1) begin
        hit_r = snoop_found & oth_r;
        chk("rand_resolve_inv", snoop_inv, (hit_r != 0 && rop[t_owner] == 1) ? oth_r : 4'b0);
        if (hit_r != 0) begin
          t_done = c + 1;
          t_src = 2'b10;
          for (int i = 3; i >= 0; i--) if (hit_r[i]) t_data = snoop_data[i*16 +: 16];
        end
      end
      if (in_txn && mem_rdy) begin
        chk("rand_mem_addr", mem_addr, raddr[t_owner]);
        t_done = c + 1;
        t_src = 2'b01;
        t_data = mem_rdata;
      end
      if (in_txn && c == t_done) begin
        chk("rand_grant", grant, 4'b1 << t_owner);
        chk("rand_fill_src", fill_src, t_src);
        if (t_src != 0) chk("rand_fill_data", fill_data, t_data);
        gnow = 4'b1 << t_owner;
        last_g = t_owner;
        rdrop[t_owner] = c + 2;
        in_txn = 0;
      end else begin
        chk("rand_no_grant", grant, 0);
        if (in_txn && c > t_start + 12) begin
          checks++;
          errors++;
          $display("FAIL rand_timeout: no grant by cycle %0d expected by %0d", c, t_start + 12);
          in_txn = 0;
        end
      end
      g2 = g1;
      g1 = gnow;
      prev_req = cur_req;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
